// File: rtl/avalon_bus_master.sv
// avalon_bus_master: single-word Avalon-MM initiator for the MIPS core load/store port.
// Optional stall timeout is compiled in by defining AVM_TIMEOUT_EN.
module avalon_bus_master #(
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byteen,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  input  logic        waitrequest
);

  typedef enum logic [1:0] {IDLE, XFER, RLAT} state_t;

  state_t      state, state_next;
  logic [31:0] address_next, writedata_next, cpu_rdata_next;
  logic [3:0]  byteenable_next;
  logic        read_next, write_next;
  logic        cpu_busy_next, cpu_done_next, cpu_err_next;
  logic        timeout_hit;

  if (READ_LATENCY != 0 && READ_LATENCY != 1) begin : g_bad_latency
    $error("avalon_bus_master: READ_LATENCY must be 0 or 1");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("avalon_bus_master: TIMEOUT_CYCLES must fit the 16-bit stall counter");
  end

`ifdef AVM_TIMEOUT_EN
  // The stall that brings the count to TIMEOUT_CYCLES is the one that aborts.
  localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] stall_cnt, stall_cnt_next;

  assign timeout_hit = (state == XFER) && waitrequest && (stall_cnt == STALL_LIMIT);

  always_comb begin
    stall_cnt_next = stall_cnt;
    if (state == IDLE)
      stall_cnt_next = '0;
    else if (state == XFER && waitrequest)
      stall_cnt_next = stall_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      stall_cnt <= '0;
    else
      stall_cnt <= stall_cnt_next;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      address    <= '0;
      writedata  <= '0;
      byteenable <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      cpu_busy   <= 1'b0;
      cpu_done   <= 1'b0;
      cpu_err    <= 1'b0;
      cpu_rdata  <= '0;
    end else begin
      state      <= state_next;
      address    <= address_next;
      writedata  <= writedata_next;
      byteenable <= byteenable_next;
      read       <= read_next;
      write      <= write_next;
      cpu_busy   <= cpu_busy_next;
      cpu_done   <= cpu_done_next;
      cpu_err    <= cpu_err_next;
      cpu_rdata  <= cpu_rdata_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cpu_req && cpu_addr[1:0] == 2'b00)
          state_next = XFER;
      end
      XFER: begin
        if (timeout_hit)
          state_next = IDLE;
        else if (!waitrequest)
          state_next = (read && READ_LATENCY == 1) ? RLAT : IDLE;
      end
      RLAT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus signals hold their values by default so they stay stable across stalls.
  always_comb begin
    address_next    = address;
    writedata_next  = writedata;
    byteenable_next = byteenable;
    read_next       = read;
    write_next      = write;
    cpu_busy_next   = cpu_busy;
    cpu_done_next   = 1'b0;
    cpu_err_next    = 1'b0;
    cpu_rdata_next  = cpu_rdata;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_addr[1:0] != 2'b00) begin
            cpu_err_next = 1'b1;
          end else begin
            address_next    = cpu_addr;
            writedata_next  = cpu_wdata;
            byteenable_next = cpu_we ? cpu_byteen : 4'b1111;
            read_next       = !cpu_we;
            write_next      = cpu_we;
            cpu_busy_next   = 1'b1;
          end
        end
      end
      XFER: begin
        if (timeout_hit) begin
          read_next     = 1'b0;
          write_next    = 1'b0;
          cpu_busy_next = 1'b0;
          cpu_err_next  = 1'b1;
        end else if (!waitrequest) begin
          read_next  = 1'b0;
          write_next = 1'b0;
          if (write || READ_LATENCY == 0) begin
            cpu_busy_next = 1'b0;
            cpu_done_next = 1'b1;
            if (read)
              cpu_rdata_next = readdata;
          end
        end
      end
      RLAT: begin
        cpu_rdata_next = readdata;
        cpu_busy_next  = 1'b0;
        cpu_done_next  = 1'b1;
      end
      default: begin
        read_next     = 1'b0;
        write_next    = 1'b0;
        cpu_busy_next = 1'b0;
      end
    endcase
  end

endmodule
